// File: rtl/return_addr_stack_if.sv
// rtl/return_addr_stack_if.sv - push/pop port bundle for the return address stack (flush under RAS_FLUSH_EN)
interface return_addr_stack_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic             push;
    logic [WIDTH-1:0] push_addr;
    logic             pop;
    logic [WIDTH-1:0] pop_addr;
    logic             pop_valid;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
`ifdef RAS_FLUSH_EN
    logic             flush;

    modport master (
        output push, push_addr, pop, flush,
        input  pop_addr, pop_valid, count, empty, full, overflow, underflow
    );
    modport slave (
        input  push, push_addr, pop, flush,
        output pop_addr, pop_valid, count, empty, full, overflow, underflow
    );
`else
    modport master (
        output push, push_addr, pop,
        input  pop_addr, pop_valid, count, empty, full, overflow, underflow
    );
    modport slave (
        input  push, push_addr, pop,
        output pop_addr, pop_valid, count, empty, full, overflow, underflow
    );
`endif
endinterface

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return address LIFO with registered pop data; RAS_FLUSH_EN adds flush
module return_addr_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    return_addr_stack_if.slave bus
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_tp;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_pop_addr;
    logic             r_pop_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic [AW-1:0]    w_top;
    logic             w_empty;
    logic             w_full;
    logic             w_flush;
    logic             w_replace;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;

`ifdef RAS_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_top     = r_tp - 1'b1;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    // Push+pop on a non-empty stack swaps the top entry in place.
    assign w_replace = bus.push && bus.pop && !w_empty;
    assign w_wr_en   = bus.push && !w_flush;
    assign w_wr_idx  = w_replace ? w_top : r_tp;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= bus.push_addr;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tp        <= '0;
            r_count     <= '0;
            r_pop_addr  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pop_valid <= 1'b0;
            if (w_flush) begin
                r_tp    <= '0;
                r_count <= '0;
            end else if (w_replace) begin
                r_pop_addr  <= r_mem[w_top];
                r_pop_valid <= 1'b1;
            end else if (bus.push) begin
                r_tp <= r_tp + 1'b1;
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
                if (bus.pop) begin
                    r_underflow <= 1'b1;
                    r_pop_addr  <= '0;
                end
            end else if (bus.pop) begin
                if (w_empty) begin
                    r_underflow <= 1'b1;
                    r_pop_addr  <= '0;
                end else begin
                    r_pop_addr  <= r_mem[w_top];
                    r_pop_valid <= 1'b1;
                    r_tp        <= w_top;
                    r_count     <= r_count - 1'b1;
                end
            end
        end
    end

    assign bus.pop_addr  = r_pop_addr;
    assign bus.pop_valid = r_pop_valid;
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_return_addr_stack.sv
// tb/tb_return_addr_stack.sv - directed and random checks of return_addr_stack against a queue model
module tb_return_addr_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    return_addr_stack_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    return_addr_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_pop_addr;
    logic             m_pop_valid;
    logic             m_ovf;
    logic             m_unf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pop_addr  = '0;
        m_pop_valid = 1'b0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
    endtask

    task automatic model_step(input bit p, input logic [WIDTH-1:0] a, input bit o, input bit f);
        m_pop_valid = 1'b0;
        if (f) begin
            m_q.delete();
        end else if (p && o && m_q.size() > 0) begin
            m_pop_addr  = m_q[m_q.size()-1];
            m_pop_valid = 1'b1;
            m_q[m_q.size()-1] = a;
        end else if (p) begin
            if (o) begin
                m_unf      = 1'b1;
                m_pop_addr = '0;
            end
            if (m_q.size() == DEPTH) begin
                m_ovf = 1'b1;
                void'(m_q.pop_front());
            end
            m_q.push_back(a);
        end else if (o) begin
            if (m_q.size() == 0) begin
                m_unf      = 1'b1;
                m_pop_addr = '0;
            end else begin
                m_pop_addr  = m_q.pop_back();
                m_pop_valid = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pop_addr"},  32'(bus.pop_addr),  32'(m_pop_addr));
        chk({tag, ".pop_valid"}, 32'(bus.pop_valid), 32'(m_pop_valid));
        chk({tag, ".count"},     32'(bus.count),     32'(m_q.size()));
        chk({tag, ".empty"},     32'(bus.empty),     32'(m_q.size() == 0));
        chk({tag, ".full"},      32'(bus.full),      32'(m_q.size() == DEPTH));
        chk({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(m_unf));
    endtask

    // Drive one cycle's inputs, clock it, then compare against the model after the edge.
    task automatic step(input string tag, input bit p, input logic [WIDTH-1:0] a, input bit o, input bit f);
        bus.push      = p;
        bus.push_addr = a;
        bus.pop       = o;
`ifdef RAS_FLUSH_EN
        bus.flush     = f;
`endif
        @(posedge clk);
        model_step(p, a, o, f);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        model_reset();
        check_all("reset");
        rst = 1'b0;
    endtask

    initial begin
        bus.push      = 1'b0;
        bus.push_addr = '0;
        bus.pop       = 1'b0;
`ifdef RAS_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        step("idle", 0, 16'h0, 0, 0);
        chk("idle.pop_addr_zero", 32'(bus.pop_addr), 32'h0);

        step("push_b", 1, 16'h000b, 0, 0);
        step("push_14", 1, 16'h0014, 0, 0);
        step("pop1", 0, 16'h0, 1, 0);
        chk("pop1.addr", 32'(bus.pop_addr), 32'h0014);
        step("pop2", 0, 16'h0, 1, 0);
        chk("pop2.addr", 32'(bus.pop_addr), 32'h000b);
        chk("pop2.empty", 32'(bus.empty), 32'h1);

        for (int i = 1; i <= 9; i++) step("fill", 1, 16'(i), 0, 0);
        chk("fill.ovf", 32'(bus.overflow), 32'h1);
        chk("fill.count", 32'(bus.count), 32'h8);
        for (int i = 9; i >= 2; i--) begin
            step("drain", 0, 16'h0, 1, 0);
            chk("drain.addr", 32'(bus.pop_addr), 32'(i));
        end

        do_reset();
        step("unf", 0, 16'h0, 1, 0);
        chk("unf.flag", 32'(bus.underflow), 32'h1);
        step("unf_push", 1, 16'h0007, 0, 0);
        chk("unf.sticky", 32'(bus.underflow), 32'h1);

        do_reset();
        step("rep_a", 1, 16'h0005, 0, 0);
        step("rep_b", 1, 16'h000b, 0, 0);
        step("rep", 1, 16'h1000, 1, 0);
        chk("rep.addr", 32'(bus.pop_addr), 32'h000b);
        chk("rep.count", 32'(bus.count), 32'h2);
        step("rep_pop", 0, 16'h0, 1, 0);
        chk("rep_pop.addr", 32'(bus.pop_addr), 32'h1000);

        do_reset();
        step("rep_empty", 1, 16'h0033, 1, 0);

        for (int i = 0; i < DEPTH; i++) step("rep_full_fill", 1, 16'(16'h0100 + i), 0, 0);
        step("rep_full", 1, 16'habcd, 1, 0);
        step("rep_full_pop", 0, 16'h0, 1, 0);

        do_reset();
        for (int i = 0; i < 5; i++) step("burst", 1, 16'(16'h0200 + i), 0, 0);
        rst = 1'b1;
        #2;
        model_reset();
        check_all("async_rst");
        #1;
        rst = 1'b0;

`ifdef RAS_FLUSH_EN
        step("fl_unf", 0, 16'h0, 1, 0);
        for (int i = 0; i < 3; i++) step("fl_fill", 1, 16'(16'h0300 + i), 0, 0);
        step("flush", 1, 16'h0400, 1, 1);
        chk("flush.count", 32'(bus.count), 32'h0);
        step("fl_after", 0, 16'h0, 1, 0);
`endif

        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 250; i++) begin
                bit p, o, f;
                p = ($urandom_range(99) < 55);
                o = ($urandom_range(99) < 45);
`ifdef RAS_FLUSH_EN
                f = ($urandom_range(99) < 3);
`else
                f = 1'b0;
`endif
                step("rand", p, 16'($urandom), o, f);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Link-address consumer for the jump-and-link path. The PC ALU produces Rlink on JAL; this block pushes it.
- On a return jump, the fetch stage pops it back as the predicted RTarget.
- Circular LIFO of DEPTH entries with registered pop data, full/empty status, and sticky overflow/underflow flags.
- Sits between the PC ALU and the fetch/PC register.

Parameters:
- WIDTH, 16, address width (matches PC/Rlink width).
- DEPTH, 8, number of entries; power of two, >= 2.
- AW, 3, pointer width = log2(DEPTH); must be set consistently with DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  push push_addr this cycle (driven from jalEN).
- push_addr  in  WIDTH  link address to store (driven from Rlink).
- pop  in  1  pop top entry this cycle (return jump).
- pop_addr  out  WIDTH  registered popped address.
- pop_valid  out  1  one-cycle pulse: pop_addr holds a real popped entry.
- count  out  AW+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a push occurred while full.
- underflow  out  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (asynchronous, active-high): tp=0, count=0, pop_addr=0, pop_valid=0, overflow=0, underflow=0, so empty=1 and full=0. Entry RAM contents are don't-care. Reset mid-operation discards all state immediately.
- Storage: DEPTH x WIDTH array; top pointer tp (AW bits) indexes the next free slot. Top entry = mem[tp-1], arithmetic mod DEPTH.
- Push only:
  - Write mem[tp] <= push_addr; tp <= tp+1 (wraps).
  - If not full: count <= count+1.
  - If full: count stays DEPTH, the oldest entry is silently overwritten, overflow <= 1.
- Pop only, not empty: pop_addr <= mem[tp-1]; pop_valid <= 1 the next cycle; tp <= tp-1; count <= count-1.
- Pop only, empty: pop_addr <= 0, pop_valid <= 0, underflow <= 1; tp and count unchanged.
- Push and pop in the same cycle:
  - Not empty: pop_addr <= mem[tp-1]; pop_valid <= 1; mem[tp-1] <= push_addr (replace top). tp, count and the flags are unchanged, even when full.
  - Empty: treated as push only, plus underflow <= 1; pop_valid <= 0, pop_addr <= 0.
- Idle cycles: pop_valid <= 0; pop_addr holds its last value.
- Latency: the pop result appears one clock after the pop edge. The push is visible to a pop in the next cycle; there is no same-cycle push-to-pop bypass except via the replace-top rule above.
- overflow and underflow clear only on reset.
- empty, full and count are combinational from registered state.

Optional Feature:
- Macro RAS_FLUSH_EN. When defined, it adds input flush (1 bit, synchronous, active-high) for branch-mispredict recovery.
- flush=1 sets tp=0 and count=0, clears pop_valid, and leaves overflow, underflow and pop_addr unchanged.
- flush has priority over push and pop in the same cycle.
- When the macro is not defined, the port does not exist and the behaviour is as above.

Test Plan:
- Reset, then idle -> empty=1, full=0, count=0, pop_addr=0000, pop_valid=0, overflow=0, underflow=0.
- Push 000b, push 0014, then pop, pop on consecutive cycles -> pop_addr=0014 with pop_valid=1, then 000b with pop_valid=1; count 2->1->0; empty=1 after.
- Push 9 values 0001..0009 with DEPTH=8 -> full=1 after the 8th push; overflow=1 after the 9th; count=8. Then 8 pops return 0009 down to 0002 (0001 was overwritten).
- Pop while empty -> pop_valid=0, pop_addr=0000, underflow=1 (stays 1 after later pushes); count=0.
- With 000b on top and count=2, assert push=1 (push_addr 1000) and pop=1 together -> pop_addr=000b with pop_valid=1; count=2; the next pop returns 1000.
- Assert reset asynchronously mid-burst of pushes (count=5) -> outputs return to reset values before the next clock edge. Under RAS_FLUSH_EN: flush with count=3 plus push -> count=0 next cycle, overflow/underflow unchanged.
